// File: rtl/csr_file.sv
// Machine-mode CSR file for the three-stage pipeline. It holds the trap CSRs,
// samples the interrupt lines, runs the 64-bit cycle counter and produces a
// one-cycle PC redirect on interrupt entry and on mret.
module csr_file #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            csr_reg_rd,
  input  logic            csr_reg_wr,
  input  logic [11:0]     csr_addr,
  input  logic [1:0]      csr_op,
  input  logic [XLEN-1:0] csr_wdata,
  input  logic [XLEN-1:0] pc_mw,
  input  logic            is_mret,
  input  logic            timer_irq,
  input  logic            ext_irq,
  output logic [XLEN-1:0] csr_rdata,
  output logic            illegal_csr,
  output logic            epc_taken,
  output logic [XLEN-1:0] epc
);

  localparam logic [11:0] ADDR_MSTATUS = 12'h300;
  localparam logic [11:0] ADDR_MIE     = 12'h304;
  localparam logic [11:0] ADDR_MTVEC   = 12'h305;
  localparam logic [11:0] ADDR_MEPC    = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
  localparam logic [11:0] ADDR_MIP     = 12'h344;
  localparam logic [11:0] ADDR_MCYCLE  = 12'hB00;
  localparam logic [11:0] ADDR_MCYCLEH = 12'hB80;

  localparam logic [3:0] CAUSE_EXT   = 4'd11;
  localparam logic [3:0] CAUSE_TIMER = 4'd7;

  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_RW   = 2'b01,
    OP_RS   = 2'b10,
    OP_RC   = 2'b11
  } csr_op_e;

  logic            mstatus_mie, mstatus_mpie;
  logic            mie_mtie, mie_meie;
  logic            mip_mtip, mip_meip;
  logic [XLEN-1:0] mtvec, mepc, mcause;
  logic [63:0]     cycle_q;

  logic            addr_hit;
  logic [XLEN-1:0] csr_old;
  logic [XLEN-1:0] wval;
  logic            wr_en;
  logic            irq_ext, irq_timer, take_irq;
  logic [3:0]      cause_code;
  logic [XLEN-1:0] trap_vec;

  // Address decode: current value of the selected CSR and whether it exists
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path infers a latch.
    csr_old  = '0;
    addr_hit = 1'b1;
    case (csr_addr)
      ADDR_MSTATUS: begin
        csr_old[3] = mstatus_mie;
        csr_old[7] = mstatus_mpie;
      end
      ADDR_MIE: begin
        csr_old[7]  = mie_mtie;
        csr_old[11] = mie_meie;
      end
      ADDR_MTVEC:   csr_old = mtvec;
      ADDR_MEPC:    csr_old = mepc;
      ADDR_MCAUSE:  csr_old = mcause;
      ADDR_MIP: begin
        csr_old[7]  = mip_mtip;
        csr_old[11] = mip_meip;
      end
      ADDR_MCYCLE:  csr_old = cycle_q[31:0];
      ADDR_MCYCLEH: csr_old = cycle_q[63:32];
      default:      addr_hit = 1'b0;
    endcase
  end

  // Read port and illegal-address flag; both forced low while reset is held
  assign csr_rdata   = (csr_reg_rd && reset) ? csr_old : '0;
  assign illegal_csr = reset & (csr_reg_rd | csr_reg_wr) & ~addr_hit;

  // Read-modify-write value for the addressed CSR
  always_comb begin
    wval = csr_old;
    case (csr_op_e'(csr_op))
      OP_RW:   wval = csr_wdata;
      OP_RS:   wval = csr_old | csr_wdata;
      OP_RC:   wval = csr_old & ~csr_wdata;
      default: wval = csr_old;
    endcase
  end

  // Interrupt arbitration; external wins, mret defers entry by one cycle
  always_comb begin
    irq_ext    = mstatus_mie & mie_meie & mip_meip;
    irq_timer  = mstatus_mie & mie_mtie & mip_mtip;
    take_irq   = (irq_ext | irq_timer) & ~is_mret;
    cause_code = irq_ext ? CAUSE_EXT : CAUSE_TIMER;
    trap_vec   = mtvec & ~XLEN'(3);
    if (mtvec[1:0] == 2'b01) trap_vec = trap_vec + XLEN'({cause_code, 2'b00});
  end

  // An entry replays the MW instruction, so its CSR write is dropped
  assign wr_en = csr_reg_wr & (csr_op != OP_NONE) & ~take_irq;

  // Interrupt request lines sampled every cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mip_mtip <= 1'b0;
      mip_meip <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
      mip_mtip <= timer_irq;
      mip_meip <= ext_irq;
    end
  end

  // Trap state: mstatus, mepc and mcause from entry, mret or a CSR write
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mstatus_mie  <= 1'b0;
      mstatus_mpie <= 1'b0;
      mepc         <= '0;
      mcause       <= '0;
    end else if (take_irq) begin
      mstatus_mpie <= mstatus_mie;
      mstatus_mie  <= 1'b0;
      mepc         <= pc_mw & ~XLEN'(3);
      mcause       <= {1'b1, {(XLEN-5){1'b0}}, cause_code};
    end else begin
      if (is_mret) begin
        mstatus_mie  <= mstatus_mpie;
        mstatus_mpie <= 1'b1;
      end else if (wr_en && csr_addr == ADDR_MSTATUS) begin
        mstatus_mie  <= wval[3];
        mstatus_mpie <= wval[7];
      end
      if (wr_en && csr_addr == ADDR_MEPC)   mepc   <= wval & ~XLEN'(3);
      if (wr_en && csr_addr == ADDR_MCAUSE) mcause <= wval;
    end
  end

  // Software-only CSRs: mie enables and the trap vector base
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mie_mtie <= 1'b0;
      mie_meie <= 1'b0;
      mtvec    <= '0;
    end else if (wr_en) begin
      if (csr_addr == ADDR_MIE) begin
        mie_mtie <= wval[7];
        mie_meie <= wval[11];
      end
      if (csr_addr == ADDR_MTVEC) mtvec <= wval;
    end
  end

  // 64-bit cycle counter; a write to either half replaces the increment
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycle_q <= '0;
    end else if (wr_en && csr_addr == ADDR_MCYCLE) begin
      cycle_q[31:0] <= wval;
    end else if (wr_en && csr_addr == ADDR_MCYCLEH) begin
      cycle_q[63:32] <= wval;
    end else begin
      cycle_q <= cycle_q + 64'd1;
    end
  end

  // One-cycle PC redirect for interrupt entry or mret
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      epc_taken <= 1'b0;
      epc       <= '0;
    end else begin
      epc_taken <= take_irq | is_mret;
      if (take_irq)     epc <= trap_vec;
      else if (is_mret) epc <= mepc;
      else              epc <= '0;
    end
  end

endmodule

// File: tb/tb_csr_file.sv
// Directed bench for csr_file: expectations are queued when a step is driven
// and popped when the matching DUT output is sampled.
module tb_csr_file;

  logic        clk = 1'b0;
  logic        reset;
  logic        csr_reg_rd, csr_reg_wr;
  logic [11:0] csr_addr;
  logic [1:0]  csr_op;
  logic [31:0] csr_wdata, pc_mw;
  logic        is_mret, timer_irq, ext_irq;
  logic [31:0] csr_rdata;
  logic        illegal_csr, epc_taken;
  logic [31:0] epc;

  typedef struct {
    string       tag;
    logic [31:0] value;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  csr_file #(.XLEN(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .csr_reg_rd  (csr_reg_rd),
    .csr_reg_wr  (csr_reg_wr),
    .csr_addr    (csr_addr),
    .csr_op      (csr_op),
    .csr_wdata   (csr_wdata),
    .pc_mw       (pc_mw),
    .is_mret     (is_mret),
    .timer_irq   (timer_irq),
    .ext_irq     (ext_irq),
    .csr_rdata   (csr_rdata),
    .illegal_csr (illegal_csr),
    .epc_taken   (epc_taken),
    .epc         (epc)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic expect_val(input string tag, input logic [31:0] value);
    exp_t item;
    item.tag   = tag;
    item.value = value;
    sb.push_back(item);
  endtask

  task automatic check(input logic [31:0] observed);
    exp_t item;
    n_checks++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard: nothing queued, observed %h", observed);
      return;
    end
    item = sb.pop_front();
    assert (observed === item.value)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", item.tag, observed, item.value);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input string tag, input logic [11:0] addr, input logic [31:0] value);
    expect_val(tag, value);
    csr_reg_rd = 1'b1;
    csr_addr   = addr;
    #1;
    check(csr_rdata);
    csr_reg_rd = 1'b0;
    csr_addr   = '0;
  endtask

  task automatic wr(input logic [11:0] addr, input logic [1:0] op, input logic [31:0] data);
    csr_reg_wr = 1'b1;
    csr_addr   = addr;
    csr_op     = op;
    csr_wdata  = data;
    tick();
    csr_reg_wr = 1'b0;
    csr_addr   = '0;
    csr_op     = 2'b00;
    csr_wdata  = '0;
  endtask

  task automatic chk_pulse(input string tag, input logic taken, input logic [31:0] target);
    expect_val({tag, "_taken"}, {31'b0, taken});
    check({31'b0, epc_taken});
    if (taken) begin
      expect_val({tag, "_epc"}, target);
      check(epc);
    end
  endtask

  initial begin
    reset = 1'b0;
    csr_reg_rd = 1'b0; csr_reg_wr = 1'b0; csr_addr = '0; csr_op = 2'b00;
    csr_wdata = '0; pc_mw = '0; is_mret = 1'b0; timer_irq = 1'b0; ext_irq = 1'b0;

    // Reset state, including gated outputs while reset is held
    tick();
    tick();
    rd("rst_mstatus", 12'h300, 32'h0);
    csr_reg_rd = 1'b1; csr_addr = 12'h7C0;
    expect_val("rst_illegal", 32'h0);
    #1 check({31'b0, illegal_csr});
    csr_reg_rd = 1'b0; csr_addr = '0;
    chk_pulse("rst", 1'b0, 32'h0);
    expect_val("rst_epc", 32'h0);
    check(epc);

    // Release and count three edges
    reset = 1'b1;
    tick(); tick(); tick();
    rd("mcycle_after_rst", 12'hB00, 32'd3);
    rd("mstatus_after_rst", 12'h300, 32'h0);

    // Basic write, same-cycle read returns the old value
    wr(12'h305, 2'b01, 32'h0000_0100);
    rd("mtvec_rw", 12'h305, 32'h100);
    csr_reg_wr = 1'b1; csr_reg_rd = 1'b1; csr_addr = 12'h342; csr_op = 2'b01; csr_wdata = 32'hABCD;
    expect_val("mcause_same_cycle_old", 32'h0);
    #1 check(csr_rdata);
    tick();
    csr_reg_wr = 1'b0; csr_reg_rd = 1'b0; csr_op = 2'b00; csr_wdata = '0;
    rd("mcause_next_cycle", 12'h342, 32'hABCD);

    // Set/clear and masking
    wr(12'h300, 2'b10, 32'hFFFF_FFFF);
    rd("mstatus_rs_mask", 12'h300, 32'h88);
    wr(12'h300, 2'b11, 32'h8);
    rd("mstatus_rc", 12'h300, 32'h80);
    wr(12'h341, 2'b01, 32'h1237);
    rd("mepc_align", 12'h341, 32'h1234);
    wr(12'h304, 2'b01, 32'hFFFF_FFFF);
    rd("mie_mask", 12'h304, 32'h880);
    wr(12'h304, 2'b01, 32'h0);
    wr(12'h344, 2'b01, 32'hFFFF_FFFF);
    rd("mip_readonly", 12'h344, 32'h0);

    // Unimplemented address
    csr_reg_wr = 1'b1; csr_addr = 12'h7C0; csr_op = 2'b01; csr_wdata = 32'h1234;
    expect_val("illegal_wr", 32'h1);
    #1 check({31'b0, illegal_csr});
    tick();
    csr_reg_wr = 1'b0; csr_op = 2'b00; csr_wdata = '0;
    rd("unimpl_readback", 12'h7C0, 32'h0);
    csr_addr = 12'h305; csr_reg_rd = 1'b1;
    expect_val("legal_no_flag", 32'h0);
    #1 check({31'b0, illegal_csr});
    csr_reg_rd = 1'b0; csr_addr = '0;

    // Vectored timer interrupt
    wr(12'h305, 2'b01, 32'h101);
    wr(12'h304, 2'b01, 32'h80);
    wr(12'h300, 2'b10, 32'h8);
    rd("mstatus_mie_set", 12'h300, 32'h88);
    pc_mw = 32'h40; timer_irq = 1'b1;
    tick();
    chk_pulse("tmr_edge1", 1'b0, 32'h0);
    rd("mip_timer", 12'h344, 32'h80);
    tick();
    chk_pulse("tmr_entry", 1'b1, 32'h11C);
    timer_irq = 1'b0;
    tick();
    chk_pulse("tmr_no_reentry", 1'b0, 32'h0);
    rd("tmr_mepc", 12'h341, 32'h40);
    rd("tmr_mcause", 12'h342, 32'h8000_0007);
    rd("tmr_mstatus", 12'h300, 32'h80);

    // Priority, dropped write in the entry cycle, then mret
    wr(12'h304, 2'b01, 32'h880);
    wr(12'h300, 2'b10, 32'h8);
    timer_irq = 1'b1; ext_irq = 1'b1;
    tick();
    chk_pulse("both_edge1", 1'b0, 32'h0);
    wr(12'h305, 2'b01, 32'hDEAD_0000);
    chk_pulse("ext_entry", 1'b1, 32'h12C);
    timer_irq = 1'b0; ext_irq = 1'b0;
    rd("ext_mcause", 12'h342, 32'h8000_000B);
    rd("collision_dropped", 12'h305, 32'h101);
    rd("ext_mstatus", 12'h300, 32'h80);
    rd("ext_mepc", 12'h341, 32'h40);
    is_mret = 1'b1;
    tick();
    is_mret = 1'b0;
    chk_pulse("mret", 1'b1, 32'h40);
    rd("mret_mstatus", 12'h300, 32'h88);
    tick();
    chk_pulse("mret_after", 1'b0, 32'h0);

    // Enabling MIE while pending: entry one edge after the write
    wr(12'h300, 2'b11, 32'h8);
    pc_mw = 32'h200; timer_irq = 1'b1;
    tick();
    chk_pulse("mie_off_pending", 1'b0, 32'h0);
    wr(12'h300, 2'b10, 32'h8);
    chk_pulse("mie_write_edge", 1'b0, 32'h0);
    tick();
    chk_pulse("mie_late_entry", 1'b1, 32'h11C);
    timer_irq = 1'b0;
    rd("late_mepc", 12'h341, 32'h200);

    // Counter carry across the 32-bit boundary
    wr(12'hB00, 2'b01, 32'hFFFF_FFFE);
    wr(12'hB80, 2'b01, 32'h0);
    rd("mcycle_held", 12'hB00, 32'hFFFF_FFFE);
    rd("mcycleh_written", 12'hB80, 32'h0);
    tick(); tick();
    rd("mcycle_wrap", 12'hB00, 32'h0);
    rd("mcycleh_carry", 12'hB80, 32'h1);

    // Reset in the middle of a redirect pulse
    is_mret = 1'b1;
    tick();
    is_mret = 1'b0;
    chk_pulse("pre_abort", 1'b1, 32'h200);
    reset = 1'b0;
    csr_reg_rd = 1'b1; csr_addr = 12'hB80;
    #1;
    chk_pulse("abort", 1'b0, 32'h0);
    expect_val("abort_epc", 32'h0);
    check(epc);
    expect_val("abort_rdata", 32'h0);
    check(csr_rdata);
    csr_reg_rd = 1'b0; csr_addr = '0;
    tick();
    reset = 1'b1;
    tick();

    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard: %0d expectations left unchecked", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
